// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the arbitrated ALU: ALUop encodings, requester count
// and default datapath widths.
package alu_arbiter_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int OPW_DEF   = 4;
   localparam int NUM_REQ   = 2;

   // ALUop encodings shared with the issue logic and the ALU itself.
   // Values not listed here produce a zero result.
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_XXX  = 4'd15
   } aluop_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters. Shifts use the low five bits of
// operand B; SLT compares signed, SLTU unsigned; unknown ops return zero.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPW-1:0]   aluop,
   output logic [WIDTH-1:0] result
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] shamt_s;
   logic           slt_s;
   logic           sltu_s;

   assign shamt_s = b[SHW-1:0];
   assign slt_s   = ($signed(a) < $signed(b));
   assign sltu_s  = (a < b);

   // Operation select.
   always_comb begin
      result = '0;
      case (aluop)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << shamt_s;
         ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt_s};
         ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_s};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt_s;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt_s);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single ALU. Each requester owns
// one registered result slot, so an accepted operation always answers on the
// following cycle. A slot being drained can be refilled in the same cycle.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int OPW   = OPW_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [OPW-1:0]   req0_aluop,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [OPW-1:0]   req1_aluop,
   output logic             rsp0_valid,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   output logic [WIDTH-1:0] rsp1_data,
   input  logic             rsp1_ready,
   output logic             busy
);

   logic [NUM_REQ-1:0] elig_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               prio_r;
   logic [WIDTH-1:0]   alu_a_s;
   logic [WIDTH-1:0]   alu_b_s;
   logic [OPW-1:0]     alu_op_s;
   logic [WIDTH-1:0]   alu_res_s;
   logic               rsp0_valid_nxt_s;
   logic               rsp1_valid_nxt_s;

   // A requester may issue when its slot is empty or is being emptied now.
   assign elig_s[0] = req0_valid & (~rsp0_valid | rsp0_ready);
   assign elig_s[1] = req1_valid & (~rsp1_valid | rsp1_ready);

   // Round-robin grant: the pointer only matters when both are eligible.
   always_comb begin
      grant_s = '0;
      if (elig_s[0] && elig_s[1]) begin
         if (prio_r) begin
            grant_s[1] = 1'b1;
         end else begin
            grant_s[0] = 1'b1;
         end
      end else if (elig_s[0]) begin
         grant_s[0] = 1'b1;
      end else if (elig_s[1]) begin
         grant_s[1] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   assign req0_ready = grant_s[0];
   assign req1_ready = grant_s[1];

   // Steer the granted operands into the ALU; idle drives a harmless op.
   always_comb begin
      alu_a_s  = '0;
      alu_b_s  = '0;
      alu_op_s = OPW'(ALU_XXX);
      if (grant_s[0]) begin
         alu_a_s  = req0_a;
         alu_b_s  = req0_b;
         alu_op_s = req0_aluop;
      end else if (grant_s[1]) begin
         alu_a_s  = req1_a;
         alu_b_s  = req1_b;
         alu_op_s = req1_aluop;
      end else begin
         alu_a_s  = '0;
         alu_b_s  = '0;
         alu_op_s = OPW'(ALU_XXX);
      end
   end

   alu_arbiter_alu #(
      .WIDTH (WIDTH),
      .OPW   (OPW)
   ) u_alu (
      .a      (alu_a_s),
      .b      (alu_b_s),
      .aluop  (alu_op_s),
      .result (alu_res_s)
   );

   // Next slot occupancy: a refill wins over a drain, so there is no bubble.
   always_comb begin
      rsp0_valid_nxt_s = rsp0_valid;
      rsp1_valid_nxt_s = rsp1_valid;
      if (grant_s[0]) begin
         rsp0_valid_nxt_s = 1'b1;
      end else if (rsp0_valid && rsp0_ready) begin
         rsp0_valid_nxt_s = 1'b0;
      end else begin
         rsp0_valid_nxt_s = rsp0_valid;
      end
      if (grant_s[1]) begin
         rsp1_valid_nxt_s = 1'b1;
      end else if (rsp1_valid && rsp1_ready) begin
         rsp1_valid_nxt_s = 1'b0;
      end else begin
         rsp1_valid_nxt_s = rsp1_valid;
      end
   end

   // Result slots, busy flag and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp1_data  <= '0;
         busy       <= 1'b0;
         prio_r     <= 1'b0;
      end else begin
         rsp0_valid <= rsp0_valid_nxt_s;
         rsp1_valid <= rsp1_valid_nxt_s;
         busy       <= rsp0_valid_nxt_s | rsp1_valid_nxt_s;
         if (grant_s[0]) begin
            rsp0_data <= alu_res_s;
         end else begin
            rsp0_data <= rsp0_data;
         end
         if (grant_s[1]) begin
            rsp1_data <= alu_res_s;
         end else begin
            rsp1_data <= rsp1_data;
         end
         if (grant_s[0]) begin
            prio_r <= 1'b1;
         end else if (grant_s[1]) begin
            prio_r <= 1'b0;
         end else begin
            prio_r <= prio_r;
         end
      end
   end

endmodule
